writeback_group_arbiter: RTL and testbench



---
 rtl/writeback_group_arbiter.sv | 127 ++++++++++++
 tb/tb_writeback_group_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_group_arbiter.sv
// Round-robin arbiter sharing one writeback group port among NUM_UNITS
// execution units; the granted ID/result is registered as a one-cycle packet.

module wbga_lane #(
  parameter int NUM_UNITS = 4,
  parameter int IDX       = 0,
  parameter int LG_W      = 2,
  parameter int RW        = LG_W + 2
) (
  input  logic [LG_W-1:0] last_grant_i,
  input  logic            done_i,
  input  logic            block_i,
  output logic            req_o,
  output logic [RW-1:0]   rank_o
);
  localparam logic [RW-1:0] IDX_W = RW'(IDX);
  localparam logic [RW-1:0] N_W   = RW'(NUM_UNITS);
  localparam logic [RW-1:0] ONE   = RW'(1);

  logic [RW-1:0] lg_w;

  assign lg_w  = RW'(last_grant_i);
  assign req_o = done_i & ~block_i;
  // Distance from last_grant+1 in search order, wrapping mod NUM_UNITS
  // without relying on power-of-2 truncation.
  assign rank_o = (IDX_W > lg_w) ? (IDX_W - lg_w - ONE)
                                 : (IDX_W + N_W - lg_w - ONE);
endmodule

module writeback_group_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_UNITS-1:0]                unit_done,
  input  logic [NUM_UNITS-1:0][ID_W-1:0]      unit_id,
  input  logic [NUM_UNITS-1:0][DATA_W-1:0]    unit_data,
  output logic [NUM_UNITS-1:0]                unit_ack,
  input  logic                                writeback_supress,
  output logic                                wb_valid,
  output logic [ID_W-1:0]                     wb_id,
  output logic [DATA_W-1:0]                   wb_data
);
  localparam int LG_W = $clog2(NUM_UNITS);
  localparam int RW   = LG_W + 2;

  logic [LG_W-1:0]                last_grant_q, last_grant_d;
  logic                           wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]                wb_id_q, wb_id_d;
  logic [DATA_W-1:0]              wb_data_q, wb_data_d;

  logic [NUM_UNITS-1:0]           req;
  logic [NUM_UNITS-1:0][RW-1:0]   rank;
  logic [NUM_UNITS-1:0]           sel;
  logic                           gnt_any;
  logic [LG_W-1:0]                gnt_idx;
  logic [ID_W-1:0]                gnt_id;
  logic [DATA_W-1:0]              gnt_data;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_lane
    wbga_lane #(
      .NUM_UNITS (NUM_UNITS),
      .IDX       (i),
      .LG_W      (LG_W),
      .RW        (RW)
    ) u_lane (
      .last_grant_i (last_grant_q),
      .done_i       (unit_done[i]),
      .block_i      (rst | writeback_supress),
      .req_o        (req[i]),
      .rank_o       (rank[i])
    );
  end

  // Ranks are distinct, so the lowest-ranked requester is unique.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      sel[i] = req[i];
      for (int j = 0; j < NUM_UNITS; j++)
        if (j != i && req[j] && (rank[j] < rank[i])) sel[i] = 1'b0;
    end
  end

  assign unit_ack = sel;

  always_comb begin
    gnt_any  = |sel;
    gnt_idx  = '0;
    gnt_id   = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel[i]) begin
        gnt_idx  = LG_W'(i);
        gnt_id   = unit_id[i];
        gnt_data = unit_data[i];
      end
    end
  end

  always_comb begin
    wb_valid_d   = gnt_any;
    wb_id_d      = gnt_any ? gnt_id   : wb_id_q;
    wb_data_d    = gnt_any ? gnt_data : wb_data_q;
    last_grant_d = gnt_any ? gnt_idx  : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q   <= 1'b0;
      wb_id_q      <= '0;
      wb_data_q    <= '0;
      last_grant_q <= LG_W'(NUM_UNITS - 1);
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_id_q      <= wb_id_d;
      wb_data_q    <= wb_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_writeback_group_arbiter.sv
// Bench for writeback_group_arbiter: directed vector table on a 4-unit
// instance, wrap check on a 3-unit instance, then randomized traffic vs a model.

module tb_writeback_group_arbiter;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]          d4_done, d4_ack;
  logic [3:0][IW-1:0]  d4_id;
  logic [3:0][DW-1:0]  d4_data;
  logic                d4_sup, d4_v;
  logic [IW-1:0]       d4_wid;
  logic [DW-1:0]       d4_wdata;

  logic [2:0]          d3_done, d3_ack;
  logic [2:0][IW-1:0]  d3_id;
  logic [2:0][DW-1:0]  d3_data;
  logic                d3_sup, d3_v;
  logic [IW-1:0]       d3_wid;
  logic [DW-1:0]       d3_wdata;

  writeback_group_arbiter #(.NUM_UNITS(4), .DATA_W(DW), .ID_W(IW)) u4 (
    .clk(clk), .rst(rst), .unit_done(d4_done), .unit_id(d4_id), .unit_data(d4_data),
    .unit_ack(d4_ack), .writeback_supress(d4_sup), .wb_valid(d4_v), .wb_id(d4_wid),
    .wb_data(d4_wdata));

  writeback_group_arbiter #(.NUM_UNITS(3), .DATA_W(DW), .ID_W(IW)) u3 (
    .clk(clk), .rst(rst), .unit_done(d3_done), .unit_id(d3_id), .unit_data(d3_data),
    .unit_ack(d3_ack), .writeback_supress(d3_sup), .wb_valid(d3_v), .wb_id(d3_wid),
    .wb_data(d3_wdata));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk last_grant+1, +2, ... mod n; first requester wins.
  function automatic int pick(input int n, input int lg, input logic [7:0] req);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (lg + k) % n;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] onehot(input int e);
    logic [7:0] v;
    v = '0;
    if (e >= 0) v[e] = 1'b1;
    return v;
  endfunction

  typedef struct {
    logic       r;
    logic       sup;
    logic [3:0] done;
    logic [3:0] ack;
    logic       v;
  } vec_t;

  vec_t vt[$];
  logic [DW-1:0] cdata4 [4];
  logic [IW-1:0] exp_id;
  logic [DW-1:0] exp_data;

  int          lg   [2];
  bit          pend [2][8];
  int          wt   [2][8];
  logic [IW-1:0] pid [2][8];
  logic [DW-1:0] pdat[2][8];
  logic [IW-1:0] gid [2];
  logic [DW-1:0] gdat[2];

  function automatic vec_t mk(input logic r, input logic s, input logic [3:0] d,
                              input logic [3:0] a, input logic v);
    vec_t x;
    x.r = r; x.sup = s; x.done = d; x.ack = a; x.v = v;
    return x;
  endfunction

  initial begin
    cdata4[0] = 32'h1111_0000; cdata4[1] = 32'hDEAD_BEEF;
    cdata4[2] = 32'h2222_0002; cdata4[3] = 32'h3333_0003;
    for (int i = 0; i < 4; i++) begin
      d4_id[i] = IW'(i + 4);
      d4_data[i] = cdata4[i];
    end
    for (int i = 0; i < 3; i++) begin
      d3_id[i] = IW'(i + 1);
      d3_data[i] = 32'hA000_0000 + DW'(i);
    end
    rst = 1'b1; d4_done = '0; d4_sup = 1'b0; d3_done = '0; d3_sup = 1'b0;

    //           r     sup   done     ack      v
    vt.push_back(mk(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));
    vt.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0));
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(1'b0, 1'b0, 4'b1111, 4'(1 << (k % 4)), 1'b1));
    for (int k = 0; k < 3; k++)
      vt.push_back(mk(1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b0101, 4'b0001, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1));
    vt.push_back(mk(1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0));
    vt.push_back(mk(1'b0, 1'b0, 4'b1110, 4'b0010, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1));
    vt.push_back(mk(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0));

    exp_id = '0; exp_data = '0;
    foreach (vt[n]) begin
      @(negedge clk);
      rst = vt[n].r; d4_sup = vt[n].sup; d4_done = vt[n].done;
      #1;
      chk($sformatf("ack4[%0d]", n), 64'(d4_ack), 64'(vt[n].ack));
      if (vt[n].r) begin
        exp_id = '0; exp_data = '0;
      end else begin
        for (int i = 0; i < 4; i++)
          if (vt[n].ack[i]) begin
            exp_id = IW'(i + 4); exp_data = cdata4[i];
          end
      end
      @(posedge clk); #1;
      chk($sformatf("wb_valid4[%0d]", n), 64'(d4_v), 64'(vt[n].v));
      chk($sformatf("wb_id4[%0d]", n), 64'(d4_wid), 64'(exp_id));
      chk($sformatf("wb_data4[%0d]", n), 64'(d4_wdata), 64'(exp_data));
    end

    // 3-unit wrap from reset: 0,1,2,0
    @(negedge clk); rst = 1'b1; d4_done = '0; d3_done = 3'b111;
    #1 chk("ack3_rst", 64'(d3_ack), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); rst = 1'b0;
      #1 chk($sformatf("ack3_wrap[%0d]", k), 64'(d3_ack), 64'(1 << (k % 3)));
      @(posedge clk); #1;
      chk($sformatf("wb_id3_wrap[%0d]", k), 64'(d3_wid), 64'((k % 3) + 1));
    end

    // Randomized request/hold traffic on both instances
    @(negedge clk); rst = 1'b1; d3_done = '0;
    @(posedge clk); #1;
    lg[0] = 3; lg[1] = 2;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) begin
        pend[k][i] = 1'b0; wt[k][i] = 0;
      end
    for (int c = 0; c < 400; c++) begin
      int e[2];
      bit sup4;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < (k == 0 ? 4 : 3); i++)
          if (!pend[k][i] && $urandom_range(2) == 0) begin
            pend[k][i] = 1'b1; wt[k][i] = 0;
            pid[k][i] = IW'($urandom_range(7)); pdat[k][i] = $urandom;
          end
      sup4 = ($urandom_range(7) == 0);
      for (int i = 0; i < 4; i++) begin
        d4_done[i] = pend[0][i]; d4_id[i] = pid[0][i]; d4_data[i] = pdat[0][i];
      end
      for (int i = 0; i < 3; i++) begin
        d3_done[i] = pend[1][i]; d3_id[i] = pid[1][i]; d3_data[i] = pdat[1][i];
      end
      d4_sup = sup4; d3_sup = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [7:0] rq;
        rq = '0;
        for (int i = 0; i < 8; i++) rq[i] = pend[k][i];
        e[k] = (k == 0 && sup4) ? -1 : pick(k == 0 ? 4 : 3, lg[k], rq);
      end
      chk("rnd_ack4", 64'(d4_ack), 64'(onehot(e[0])));
      chk("rnd_ack3", 64'(d3_ack), 64'(onehot(e[1])));
      for (int k = 0; k < 2; k++) begin
        int n;
        n = (k == 0) ? 4 : 3;
        for (int i = 0; i < n; i++)
          if (pend[k][i]) begin
            if (!(k == 0 && sup4)) wt[k][i]++;
            if (i == e[k]) begin
              chk($sformatf("fair%0d_u%0d_wait_le_n", n, i), 64'(wt[k][i] <= n), 64'd1);
              pend[k][i] = 1'b0;
              gid[k] = pid[k][i]; gdat[k] = pdat[k][i];
            end
          end
      end
      @(posedge clk); #1;
      chk("rnd_valid4", 64'(d4_v), 64'(e[0] >= 0));
      chk("rnd_valid3", 64'(d3_v), 64'(e[1] >= 0));
      if (e[0] >= 0) begin
        chk("rnd_id4", 64'(d4_wid), 64'(gid[0]));
        chk("rnd_data4", 64'(d4_wdata), 64'(gdat[0]));
        lg[0] = e[0];
      end
      if (e[1] >= 0) begin
        chk("rnd_id3", 64'(d3_wid), 64'(gid[1]));
        chk("rnd_data3", 64'(d3_wdata), 64'(gdat[1]));
        lg[1] = e[1];
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
